pipe_host_ctrl: RTL and testbench
=================================

PIPE_HOST_CTRL -- requirements
Module: pipe_host_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: cmd_valid in 1; cmd_ready out 1; cmd_op in 3; cmd_addr in 9; cmd_wdata in 64 (host command channel).
REQ-004 SHALL have: rsp_valid out 1; rsp_err out 1; rsp_data out 64 (one-cycle response, no backpressure).
REQ-005 SHALL have: run out 1; step out 1; pc_reset_pulse out 1 (pipeline sequencing).
REQ-006 SHALL have: imem_prog_we out 1; imem_prog_addr out 9; imem_prog_wdata out 32.
REQ-007 SHALL have: dmem_prog_en out 1; dmem_prog_we out 1; dmem_prog_addr out 8; dmem_prog_wdata out 64; dmem_prog_rdata in 64 (D-mem port B, 1-cycle read latency).

Function
REQ-008 Command SHALL be accepted on a rising edge where cmd_valid & cmd_ready; cmd_ready SHALL be 1 only in IDLE.
REQ-009 States SHALL be IDLE, IWR, DWR, DRD0, DRD1, STEP_HI, STEP_LO, PCRST, RSP.
REQ-010 Every accepted command SHALL produce exactly one rsp_valid=1 cycle (state RSP), then return to IDLE; rsp_err/rsp_data SHALL be valid only with rsp_valid, else 0.
REQ-011 Op 0 STATUS: -> RSP; rsp_data = {31'b0, run, cycle_cnt[31:0]}.
REQ-012 Op 1 IMEM_WR: if run=1 -> RSP with rsp_err=1, no write; else IWR: imem_prog_we=1 one cycle, addr=cmd_addr, wdata=cmd_wdata[31:0], then RSP.
REQ-013 Op 2 DMEM_WR: DWR: dmem_prog_en=1, dmem_prog_we=1 one cycle, addr=cmd_addr[7:0], wdata=cmd_wdata; then RSP; allowed while run=1.
REQ-014 Op 3 DMEM_RD: DRD0 en=1 we=0 addr=cmd_addr[7:0]; DRD1 en=0, dmem_prog_rdata captured at end of DRD1; RSP returns captured word.
REQ-015 Op 4 RUN_START: run<=1 (idempotent); op 5 RUN_STOP: run<=0 (idempotent); both -> RSP, rsp_data=0.
REQ-016 Op 6 STEP: n=cmd_wdata[15:0]; run=1 -> RSP rsp_err=1; n=0 -> RSP, no pulse; else n repetitions of STEP_HI (step=1) then STEP_LO (step=0), 16-bit down-counter, RSP after final STEP_LO.
REQ-017 step SHALL never be high two consecutive cycles (pipeline edge-detects step).
REQ-018 Op 7 PC_RESET: PCRST asserts pc_reset_pulse exactly one cycle; run unchanged; then RSP.
REQ-019 Accepted-command latency: IWR/DWR/PCRST ops rsp_valid 2 cycles after accept edge; DMEM_RD 3 cycles; STATUS/RUN ops 1 cycle; STEP n>0 2n+1 cycles.
REQ-020 imem_prog_*, dmem_prog_* address/data outputs SHALL be 0 outside their active states.

Reset
REQ-021 reset_n=0 SHALL immediately (asynchronously) force state=IDLE, run=0, step=0, pc_reset_pulse=0, all prog enables/addresses/data=0, rsp_*=0, step counter=0, cycle_cnt=0; cmd_ready=1 from first edge after deassertion.
REQ-022 Reset mid-operation SHALL abort the command with no response issued.

Configuration
REQ-023 Macro PHC_CYCLE_COUNT_EN defined: 32-bit cycle_cnt increments (wrapping 0xFFFFFFFF->0) on each cycle with run=1 or step=1, cleared by PC_RESET.
REQ-024 Macro undefined: no counter logic; cycle_cnt field of STATUS reads 0.

Verification
REQ-025 IMEM_WR addr=0x1A5 data=0xDEADBEEF, run=0 -> imem_prog_we one cycle with those values; rsp_valid 2 cycles after accept, rsp_err=0.
REQ-026 RUN_START then IMEM_WR -> rsp_err=1, imem_prog_we never asserted; RUN_STOP -> run=0.
REQ-027 DMEM_WR addr=0x10 data=0x0123456789ABCDEF, then DMEM_RD addr=0x10 -> rsp_data=0x0123456789ABCDEF, 3 cycles after accept.
REQ-028 STEP n=3 -> step pattern 1,0,1,0,1,0; rsp_valid after 7 cycles; STEP n=0 -> no step pulse, rsp 1 cycle.
REQ-029 STEP n=100, reset_n low after 5th pulse -> all outputs 0 same cycle, no rsp; cmd_ready=1 after release.
REQ-030 PHC_CYCLE_COUNT_EN: RUN_START, 10 cycles, RUN_STOP, STATUS -> rsp_data[31:0] equals counted run cycles; PC_RESET then STATUS -> 0; without macro always 0.

Source files
------------

// File: rtl/pipe_host_ctrl.sv
// Host command controller: programs I/D memories, starts/stops/single-steps the pipeline and pulses its PC reset.
// Optional feature: define PHC_CYCLE_COUNT_EN to build the 32-bit run/step cycle counter reported by STATUS.
module pipe_host_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  // Command channel: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE. Each command yields exactly one rsp_valid cycle (no backpressure).
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [8:0]  cmd_addr,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [63:0] rsp_data,
  output logic        run,
  output logic        step,
  output logic        pc_reset_pulse,
  output logic        imem_prog_we,
  output logic [8:0]  imem_prog_addr,
  output logic [31:0] imem_prog_wdata,
  output logic        dmem_prog_en,
  output logic        dmem_prog_we,
  output logic [7:0]  dmem_prog_addr,
  output logic [63:0] dmem_prog_wdata,
  input  logic [63:0] dmem_prog_rdata,
  output logic [3:0]  o_dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_IWR     = 4'd1,
    S_DWR     = 4'd2,
    S_DRD0    = 4'd3,
    S_DRD1    = 4'd4,
    S_STEP_HI = 4'd5,
    S_STEP_LO = 4'd6,
    S_PCRST   = 4'd7,
    S_RSP     = 4'd8
  } state_t;

  localparam logic [2:0] OP_STATUS    = 3'd0;
  localparam logic [2:0] OP_IMEM_WR   = 3'd1;
  localparam logic [2:0] OP_DMEM_WR   = 3'd2;
  localparam logic [2:0] OP_DMEM_RD   = 3'd3;
  localparam logic [2:0] OP_RUN_START = 3'd4;
  localparam logic [2:0] OP_RUN_STOP  = 3'd5;
  localparam logic [2:0] OP_STEP      = 3'd6;
  localparam logic [2:0] OP_PC_RESET  = 3'd7;

  state_t      r_state;
  state_t      w_next;
  logic        r_rdy;
  logic        r_run;
  logic [8:0]  r_addr;
  logic [63:0] r_wdata;
  logic        r_rsp_err;
  logic [63:0] r_rsp_data;
  logic [15:0] r_step_cnt;
  logic [31:0] w_cnt;
  logic        w_accept;
  logic        w_step;

  assign w_accept = cmd_valid && cmd_ready;
  assign w_step   = (r_state == S_STEP_HI);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_IMEM_WR:  w_next = r_run ? S_RSP : S_IWR;
            OP_DMEM_WR:  w_next = S_DWR;
            OP_DMEM_RD:  w_next = S_DRD0;
            OP_STEP:     w_next = (r_run || (cmd_wdata[15:0] == 16'd0)) ? S_RSP : S_STEP_HI;
            OP_PC_RESET: w_next = S_PCRST;
            default:     w_next = S_RSP;
          endcase
        end
      end
      S_IWR, S_DWR, S_PCRST, S_DRD1: w_next = S_RSP;
      S_DRD0:    w_next = S_DRD1;
      S_STEP_HI: w_next = S_STEP_LO;
      // A full low cycle always separates two step pulses.
      S_STEP_LO: w_next = (r_step_cnt == 16'd1) ? S_RSP : S_STEP_HI;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rdy      <= 1'b0;
      r_run      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_err  <= 1'b0;
      r_rsp_data <= '0;
      r_step_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_rdy   <= 1'b1;
      if (w_accept) begin
        r_addr     <= cmd_addr;
        r_wdata    <= cmd_wdata;
        r_rsp_err  <= 1'b0;
        r_rsp_data <= '0;
        case (cmd_op)
          OP_STATUS:    r_rsp_data <= {31'b0, r_run, w_cnt};
          OP_IMEM_WR:   r_rsp_err  <= r_run;
          OP_RUN_START: r_run      <= 1'b1;
          OP_RUN_STOP:  r_run      <= 1'b0;
          OP_STEP: begin
            r_rsp_err  <= r_run;
            r_step_cnt <= r_run ? 16'd0 : cmd_wdata[15:0];
          end
          default: ;
        endcase
      end
      if (r_state == S_STEP_LO) r_step_cnt <= r_step_cnt - 16'd1;
      // Port B returned the word during DRD1; latch it for the response.
      if (r_state == S_DRD1) r_rsp_data <= dmem_prog_rdata;
    end
  end

`ifdef PHC_CYCLE_COUNT_EN
  logic [31:0] r_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state == S_PCRST) begin
      r_cnt <= '0;
    end else if (r_run || w_step) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end
  assign w_cnt = r_cnt;
`else
  assign w_cnt = '0;
`endif

  assign cmd_ready       = r_rdy && (r_state == S_IDLE);
  assign rsp_valid       = (r_state == S_RSP);
  assign rsp_err         = (r_state == S_RSP) && r_rsp_err;
  assign rsp_data        = (r_state == S_RSP) ? r_rsp_data : '0;
  assign run             = r_run;
  assign step            = w_step;
  assign pc_reset_pulse  = (r_state == S_PCRST);
  assign imem_prog_we    = (r_state == S_IWR);
  assign imem_prog_addr  = (r_state == S_IWR) ? r_addr : '0;
  assign imem_prog_wdata = (r_state == S_IWR) ? r_wdata[31:0] : '0;
  assign dmem_prog_en    = (r_state == S_DWR) || (r_state == S_DRD0);
  assign dmem_prog_we    = (r_state == S_DWR);
  assign dmem_prog_addr  = ((r_state == S_DWR) || (r_state == S_DRD0)) ? r_addr[7:0] : '0;
  assign dmem_prog_wdata = (r_state == S_DWR) ? r_wdata : '0;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_pipe_host_ctrl.sv
// Directed bench for pipe_host_ctrl: command latencies, memory programming, stepping, run lockout, resets.
module tb_pipe_host_ctrl;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [8:0]  cmd_addr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [63:0] rsp_data;
  logic        run;
  logic        step;
  logic        pc_reset_pulse;
  logic        imem_prog_we;
  logic [8:0]  imem_prog_addr;
  logic [31:0] imem_prog_wdata;
  logic        dmem_prog_en;
  logic        dmem_prog_we;
  logic [7:0]  dmem_prog_addr;
  logic [63:0] dmem_prog_wdata;
  logic [63:0] dmem_prog_rdata;
  logic [3:0]  o_dbg_state;

  int checks = 0;
  int fails  = 0;

  pipe_host_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_err         (rsp_err),
    .rsp_data        (rsp_data),
    .run             (run),
    .step            (step),
    .pc_reset_pulse  (pc_reset_pulse),
    .imem_prog_we    (imem_prog_we),
    .imem_prog_addr  (imem_prog_addr),
    .imem_prog_wdata (imem_prog_wdata),
    .dmem_prog_en    (dmem_prog_en),
    .dmem_prog_we    (dmem_prog_we),
    .dmem_prog_addr  (dmem_prog_addr),
    .dmem_prog_wdata (dmem_prog_wdata),
    .dmem_prog_rdata (dmem_prog_rdata),
    .o_dbg_state     (o_dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // D-mem port B model, 1-cycle read latency
  logic [63:0] mem [0:255];
  initial dmem_prog_rdata = '0;
  always @(posedge clk) begin
    if (dmem_prog_en) begin
      if (dmem_prog_we) mem[dmem_prog_addr] <= dmem_prog_wdata;
      else              dmem_prog_rdata <= mem[dmem_prog_addr];
    end
  end

  // output monitors, sampled on the falling edge
  int          imem_cnt  = 0;
  logic [8:0]  imem_a    = '0;
  logic [31:0] imem_d    = '0;
  int          pc_cnt    = 0;
  int          step_cnt  = 0;
  int          step_dbl  = 0;
  int          bad_idle  = 0;
  logic        prev_step = 1'b0;
  logic [31:0] step_hist = '0;

  always @(negedge clk) begin
    if (imem_prog_we) begin
      imem_cnt = imem_cnt + 1;
      imem_a   = imem_prog_addr;
      imem_d   = imem_prog_wdata;
    end
    if (pc_reset_pulse) pc_cnt = pc_cnt + 1;
    if (step) step_cnt = step_cnt + 1;
    if (step && prev_step) step_dbl = step_dbl + 1;
    prev_step = step;
    step_hist = {step_hist[30:0], step};
    if (!imem_prog_we && (imem_prog_addr != '0 || imem_prog_wdata != '0)) bad_idle = bad_idle + 1;
    if (!dmem_prog_en && (dmem_prog_addr != '0 || dmem_prog_wdata != '0 || dmem_prog_we)) bad_idle = bad_idle + 1;
    if (dmem_prog_en && !dmem_prog_we && dmem_prog_wdata != '0) bad_idle = bad_idle + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: call at #1 after a rising edge; returns #1 after the edge that raised rsp_valid
  task automatic do_cmd(input logic [2:0] op, input logic [8:0] addr, input logic [63:0] wd,
                        output int lat, output logic err, output logic [63:0] data);
    int waits;
    waits     = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    while (!cmd_ready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    lat = 1;
    while (!rsp_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    err  = rsp_err;
    data = rsp_data;
    if (!rsp_valid) lat = -1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, run, step, pc_reset_pulse, imem_prog_we, dmem_prog_en, dmem_prog_we} !== 9'b0) begin
      fails++;
      $display("FAIL reset_ctrl_outs: got %b expected 000000000",
               {cmd_ready, rsp_valid, rsp_err, run, step, pc_reset_pulse, imem_prog_we, dmem_prog_en, dmem_prog_we});
    end
    checks++;
    if (o_dbg_state !== 4'd0 || rsp_data !== 64'd0) begin
      fails++;
      $display("FAIL reset_state: got state %0d data %h expected state 0 data 0", o_dbg_state, rsp_data);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge: got %b expected 0", cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_edge: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_status();
    int lat; logic err; logic [63:0] d;
    do_cmd(3'd0, 9'd0, 64'd0, lat, err, d);
    checks++;
    if (lat !== 1 || err !== 1'b0 || d !== 64'd0) begin
      fails++;
      $display("FAIL status_reset: got lat %0d err %b data %h expected lat 1 err 0 data 0", lat, err, d);
    end
  endtask

  task automatic test_imem_wr();
    int lat; logic err; logic [63:0] d; int base;
    base = imem_cnt;
    do_cmd(3'd1, 9'h1A5, 64'hFFFF0000DEADBEEF, lat, err, d);
    checks++;
    if (lat !== 2 || err !== 1'b0 || d !== 64'd0) begin
      fails++;
      $display("FAIL imem_wr_rsp: got lat %0d err %b data %h expected lat 2 err 0 data 0", lat, err, d);
    end
    checks++;
    if (imem_cnt - base !== 1 || imem_a !== 9'h1A5 || imem_d !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL imem_wr_port: got pulses %0d addr %h data %h expected 1 1a5 deadbeef",
               imem_cnt - base, imem_a, imem_d);
    end
  endtask

  task automatic test_run_lockout();
    int lat; logic err; logic [63:0] d; int base; int sbase;
    do_cmd(3'd4, 9'd0, 64'd5, lat, err, d);
    checks++;
    if (lat !== 1 || err !== 1'b0 || d !== 64'd0 || run !== 1'b1) begin
      fails++;
      $display("FAIL run_start: got lat %0d err %b data %h run %b expected 1 0 0 1", lat, err, d, run);
    end
    do_cmd(3'd4, 9'd0, 64'd0, lat, err, d);
    checks++;
    if (lat !== 1 || run !== 1'b1) begin
      fails++;
      $display("FAIL run_start_again: got lat %0d run %b expected 1 1", lat, run);
    end
    do_cmd(3'd0, 9'd0, 64'd0, lat, err, d);
    checks++;
    if (lat !== 1 || d[63:32] !== 32'h1) begin
      fails++;
      $display("FAIL status_running: got lat %0d hi %h expected 1 00000001", lat, d[63:32]);
    end
    base = imem_cnt;
    do_cmd(3'd1, 9'h055, 64'h12345678, lat, err, d);
    checks++;
    if (lat !== 1 || err !== 1'b1 || imem_cnt - base !== 0) begin
      fails++;
      $display("FAIL imem_locked: got lat %0d err %b pulses %0d expected 1 1 0", lat, err, imem_cnt - base);
    end
    sbase = step_cnt;
    do_cmd(3'd6, 9'd0, 64'd4, lat, err, d);
    checks++;
    if (lat !== 1 || err !== 1'b1 || step_cnt - sbase !== 0) begin
      fails++;
      $display("FAIL step_locked: got lat %0d err %b pulses %0d expected 1 1 0", lat, err, step_cnt - sbase);
    end
    do_cmd(3'd2, 9'h020, 64'hA5A5_5A5A_0F0F_F0F0, lat, err, d);
    checks++;
    if (lat !== 2 || err !== 1'b0) begin
      fails++;
      $display("FAIL dmem_wr_running: got lat %0d err %b expected 2 0", lat, err);
    end
    do_cmd(3'd5, 9'd0, 64'd0, lat, err, d);
    checks++;
    if (lat !== 1 || err !== 1'b0 || d !== 64'd0 || run !== 1'b0) begin
      fails++;
      $display("FAIL run_stop: got lat %0d err %b data %h run %b expected 1 0 0 0", lat, err, d, run);
    end
  endtask

  task automatic test_dmem();
    int lat; logic err; logic [63:0] d;
    do_cmd(3'd2, 9'h010, 64'h0123456789ABCDEF, lat, err, d);
    checks++;
    if (lat !== 2 || err !== 1'b0 || d !== 64'd0) begin
      fails++;
      $display("FAIL dmem_wr: got lat %0d err %b data %h expected 2 0 0", lat, err, d);
    end
    do_cmd(3'd2, 9'h1FF, 64'hFEDCBA9876543210, lat, err, d);
    do_cmd(3'd3, 9'h010, 64'd0, lat, err, d);
    checks++;
    if (lat !== 3 || err !== 1'b0 || d !== 64'h0123456789ABCDEF) begin
      fails++;
      $display("FAIL dmem_rd_10: got lat %0d err %b data %h expected 3 0 0123456789abcdef", lat, err, d);
    end
    do_cmd(3'd3, 9'h020, 64'd0, lat, err, d);
    checks++;
    if (lat !== 3 || d !== 64'hA5A5_5A5A_0F0F_F0F0) begin
      fails++;
      $display("FAIL dmem_rd_20: got lat %0d data %h expected 3 a5a55a5a0f0ff0f0", lat, d);
    end
    do_cmd(3'd3, 9'h0FF, 64'd0, lat, err, d);
    checks++;
    if (lat !== 3 || d !== 64'hFEDCBA9876543210) begin
      fails++;
      $display("FAIL dmem_rd_ff: got lat %0d data %h expected 3 fedcba9876543210", lat, d);
    end
  endtask

  task automatic test_step();
    int lat; logic err; logic [63:0] d; int sbase;
    sbase = step_cnt;
    do_cmd(3'd6, 9'd0, 64'hFFFF_0000_0000_0003, lat, err, d);
    checks++;
    if (lat !== 7 || err !== 1'b0 || step_cnt - sbase !== 3) begin
      fails++;
      $display("FAIL step3: got lat %0d err %b pulses %0d expected 7 0 3", lat, err, step_cnt - sbase);
    end
    checks++;
    if (step_hist[5:0] !== 6'b101010) begin
      fails++;
      $display("FAIL step3_pattern: got %b expected 101010", step_hist[5:0]);
    end
    sbase = step_cnt;
    do_cmd(3'd6, 9'd0, 64'h0000_0000_0001_0000, lat, err, d);
    checks++;
    if (lat !== 1 || err !== 1'b0 || step_cnt - sbase !== 0) begin
      fails++;
      $display("FAIL step0: got lat %0d err %b pulses %0d expected 1 0 0", lat, err, step_cnt - sbase);
    end
    sbase = step_cnt;
    do_cmd(3'd6, 9'd0, 64'd1, lat, err, d);
    checks++;
    if (lat !== 3 || step_cnt - sbase !== 1) begin
      fails++;
      $display("FAIL step1: got lat %0d pulses %0d expected 3 1", lat, step_cnt - sbase);
    end
  endtask

  task automatic test_pc_reset();
    int lat; logic err; logic [63:0] d; int pbase;
    do_cmd(3'd4, 9'd0, 64'd0, lat, err, d);
    pbase = pc_cnt;
    do_cmd(3'd7, 9'd0, 64'd0, lat, err, d);
    checks++;
    if (lat !== 2 || err !== 1'b0 || pc_cnt - pbase !== 1 || run !== 1'b1) begin
      fails++;
      $display("FAIL pc_reset_running: got lat %0d err %b pulses %0d run %b expected 2 0 1 1",
               lat, err, pc_cnt - pbase, run);
    end
    do_cmd(3'd5, 9'd0, 64'd0, lat, err, d);
    pbase = pc_cnt;
    do_cmd(3'd7, 9'd0, 64'd0, lat, err, d);
    checks++;
    if (lat !== 2 || pc_cnt - pbase !== 1 || run !== 1'b0) begin
      fails++;
      $display("FAIL pc_reset_idle: got lat %0d pulses %0d run %b expected 2 1 0", lat, pc_cnt - pbase, run);
    end
  endtask

  task automatic test_cycle_count();
    int lat; logic err; logic [63:0] d; logic [31:0] exp_run;
`ifdef PHC_CYCLE_COUNT_EN
    // run rises on the RUN_START accept edge and falls on the RUN_STOP accept edge,
    // which lands 11 edges later: 10 idle cycles plus the RSP->IDLE edge.
    exp_run = 32'd11;
`else
    exp_run = 32'd0;
`endif
    do_cmd(3'd7, 9'd0, 64'd0, lat, err, d);
    do_cmd(3'd0, 9'd0, 64'd0, lat, err, d);
    checks++;
    if (lat !== 1 || d !== 64'd0) begin
      fails++;
      $display("FAIL cnt_cleared: got lat %0d data %h expected 1 0", lat, d);
    end
    do_cmd(3'd4, 9'd0, 64'd0, lat, err, d);
    repeat (10) begin
      @(posedge clk); #1;
    end
    do_cmd(3'd5, 9'd0, 64'd0, lat, err, d);
    do_cmd(3'd0, 9'd0, 64'd0, lat, err, d);
    checks++;
    if (lat !== 1 || d !== {32'd0, exp_run}) begin
      fails++;
      $display("FAIL cnt_run: got lat %0d data %h expected 1 %h", lat, d, {32'd0, exp_run});
    end
    do_cmd(3'd7, 9'd0, 64'd0, lat, err, d);
    do_cmd(3'd0, 9'd0, 64'd0, lat, err, d);
    checks++;
    if (d !== 64'd0) begin
      fails++;
      $display("FAIL cnt_after_pc_reset: got %h expected 0", d);
    end
  endtask

  task automatic test_reset_mid_step();
    int lat; logic err; logic [63:0] d; int pulses; int guard; int rsp_seen;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd6;
    cmd_addr  = '0;
    cmd_wdata = 64'd100;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_wdata = '0;
    pulses = 0;
    guard  = 0;
    while (pulses < 5 && guard < 50) begin
      @(negedge clk);
      if (step) pulses++;
      guard++;
    end
    checks++;
    if (pulses !== 5) begin
      fails++;
      $display("FAIL mid_step_pulses: got %0d expected 5", pulses);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, run, step, pc_reset_pulse, imem_prog_we, dmem_prog_en, dmem_prog_we,
         o_dbg_state, rsp_data, imem_prog_addr, imem_prog_wdata, dmem_prog_addr, dmem_prog_wdata} !== '0) begin
      fails++;
      $display("FAIL async_reset_outs: got ctrl %b state %0d step %b expected all zero",
               {cmd_ready, rsp_valid, rsp_err, run, pc_reset_pulse}, o_dbg_state, step);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    rsp_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid) rsp_seen++;
    end
    checks++;
    if (rsp_seen !== 0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_abort: got rsp cycles %0d ready %b expected 0 1", rsp_seen, cmd_ready);
    end
    do_cmd(3'd0, 9'd0, 64'd0, lat, err, d);
    checks++;
    if (lat !== 1 || d !== 64'd0) begin
      fails++;
      $display("FAIL status_after_reset: got lat %0d data %h expected 1 0", lat, d);
    end
  endtask

  task automatic test_port_hygiene();
    checks++;
    if (step_dbl !== 0) begin
      fails++;
      $display("FAIL step_double_high: got %0d expected 0", step_dbl);
    end
    checks++;
    if (bad_idle !== 0) begin
      fails++;
      $display("FAIL prog_ports_idle: got %0d nonzero cycles expected 0", bad_idle);
    end
  endtask

  initial begin
    test_reset();
    test_status();
    test_imem_wr();
    test_run_lockout();
    test_dmem();
    test_step();
    test_pc_reset();
    test_cycle_count();
    test_reset_mid_step();
    test_port_hygiene();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
